// File: rtl/ctrl_bus_arbiter.sv
// ctrl_bus_arbiter: round-robin arbiter sharing the synth controller bus (write/adr/data/selects) among N_REQ parameter sources.
// Latency: accept at T, adr/data/select driven from T+1, write strobe at T+2, bus free again at T+3+HOLD_CYC.
// Backpressure: req_ready pulses only while IDLE; a requester holds valid/adr/data stable until it sees its ready bit.
module ctrl_bus_arbiter #(
  parameter int N_REQ    = 3,
  parameter int HOLD_CYC = 1,
  parameter int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                sysclk,
  input  logic                reset1,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*10-1:0] req_adr,
  input  logic [N_REQ*8-1:0]  req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                write,
  output logic [6:0]          adr,
  output logic [7:0]          data,
  output logic                env_sel,
  output logic                osc_sel,
  output logic                m1_sel,
  output logic                m2_sel,
  output logic                com_sel,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic                err_badadr
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    hold_cnt;
  logic [2:0]    hold_cnt_nxt;
  logic [GW-1:0] last_grant;
  logic [4:0]    sel_q;

  int            rr_idx;
  int            pick_idx;
  logic          pick_vld;
  logic [9:0]    pick_adr;
  logic [7:0]    pick_data;
  logic [4:0]    pick_sel;
  logic          pick_bad;
  logic          accept;

  // Round-robin search: first valid requester starting one past the last grant, wrapping below N_REQ.
  always_comb begin
    rr_idx   = 0;
    pick_idx = 0;
    pick_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = int'(last_grant) + 1 + k;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      if (!pick_vld && req_valid[rr_idx]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx;
      end
    end
  end

  // Select the winner's address/data and decode its section into a one-hot select.
  always_comb begin
    pick_adr  = req_adr[pick_idx*10 +: 10];
    pick_data = req_data[pick_idx*8 +: 8];
    pick_sel  = 5'b00000;
    pick_bad  = 1'b0;
    case (pick_adr[9:7])
      3'd0:    pick_sel = 5'b00001;
      3'd1:    pick_sel = 5'b00010;
      3'd2:    pick_sel = 5'b00100;
      3'd3:    pick_sel = 5'b01000;
      3'd4:    pick_sel = 5'b10000;
      default: pick_bad = 1'b1;
    endcase
  end

  // Accept only while IDLE and out of reset; ready is a single-bit pulse to the winner.
  always_comb begin
    accept    = reset1 && (state == IDLE) && pick_vld;
    req_ready = '0;
    if (accept) req_ready[pick_idx] = 1'b1;
  end

  // State register and hold counter.
  always_ff @(posedge sysclk or negedge reset1) begin
    if (!reset1) begin
      state    <= IDLE;
      hold_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next-state and bus strobe/select outputs; selects are only driven outside IDLE.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    write        = 1'b0;
    busy         = 1'b0;
    env_sel      = 1'b0;
    osc_sel      = 1'b0;
    m1_sel       = 1'b0;
    m2_sel       = 1'b0;
    com_sel      = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !pick_bad) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = STROBE;
      end
      STROBE: begin
        write        = 1'b1;
        state_nxt    = HOLD;
        hold_cnt_nxt = 3'(HOLD_CYC - 1);
      end
      HOLD: begin
        if (hold_cnt == 3'd0) state_nxt = IDLE;
        else hold_cnt_nxt = hold_cnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      busy    = 1'b1;
      env_sel = sel_q[0];
      osc_sel = sel_q[1];
      m1_sel  = sel_q[2];
      m2_sel  = sel_q[3];
      com_sel = sel_q[4];
    end
  end

  // Latch the accepted request; bad sections still consume the request and raise a one-cycle error.
  always_ff @(posedge sysclk or negedge reset1) begin
    if (!reset1) begin
      adr        <= 7'd0;
      data       <= 8'd0;
      grant_id   <= '0;
      sel_q      <= 5'd0;
      last_grant <= GW'(N_REQ - 1);
      err_badadr <= 1'b0;
    end else begin
      err_badadr <= accept && pick_bad;
      if (accept) begin
        adr        <= pick_adr[6:0];
        data       <= pick_data;
        grant_id   <= GW'(pick_idx);
        sel_q      <= pick_sel;
        last_grant <= GW'(pick_idx);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// tb_ctrl_bus_arbiter: directed, table-driven and randomized checks of ctrl_bus_arbiter.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: stimulus requesters hold each request until granted (or occasionally withdraw it).
`timescale 1ns/1ps
module tb_ctrl_bus_arbiter;
  localparam int N  = 3;
  localparam int H  = 1;
  localparam int GW = 2;
  localparam int NV = 7;

  logic            sysclk    = 1'b0;
  logic            reset1    = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*10-1:0] req_adr   = '0;
  logic [N*8-1:0]  req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            write, busy, err_badadr;
  logic [6:0]      adr;
  logic [7:0]      data;
  logic            env_sel, osc_sel, m1_sel, m2_sel, com_sel;
  logic [GW-1:0]   grant_id;

  logic [N-1:0]    b_valid = '0;
  logic [N*10-1:0] b_adr   = '0;
  logic [N*8-1:0]  b_data  = '0;
  logic [N-1:0]    b_ready;
  logic            b_write, b_busy, b_err;
  logic [6:0]      b_adr_o;
  logic [7:0]      b_data_o;
  logic            b_env, b_osc, b_m1, b_m2, b_com;
  logic [GW-1:0]   b_gid;

  logic [4:0] sel;
  assign sel = {com_sel, m2_sel, m1_sel, osc_sel, env_sel};

  ctrl_bus_arbiter #(.N_REQ(N), .HOLD_CYC(H)) dut (
    .sysclk(sysclk), .reset1(reset1), .req_valid(req_valid), .req_adr(req_adr),
    .req_data(req_data), .req_ready(req_ready), .write(write), .adr(adr), .data(data),
    .env_sel(env_sel), .osc_sel(osc_sel), .m1_sel(m1_sel), .m2_sel(m2_sel), .com_sel(com_sel),
    .grant_id(grant_id), .busy(busy), .err_badadr(err_badadr)
  );

  ctrl_bus_arbiter #(.N_REQ(N), .HOLD_CYC(3)) dut_h3 (
    .sysclk(sysclk), .reset1(reset1), .req_valid(b_valid), .req_adr(b_adr),
    .req_data(b_data), .req_ready(b_ready), .write(b_write), .adr(b_adr_o), .data(b_data_o),
    .env_sel(b_env), .osc_sel(b_osc), .m1_sel(b_m1), .m2_sel(b_m2), .com_sel(b_com),
    .grant_id(b_gid), .busy(b_busy), .err_badadr(b_err)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic mid();
    @(negedge sysclk);
  endtask

  function automatic logic [31:0] pack0();
    return {4'b0, req_ready, write, busy, sel, adr, data, grant_id, err_badadr};
  endfunction

  function automatic logic [31:0] pack1();
    return {4'b0, b_ready, b_write, b_busy, b_com, b_m2, b_m1, b_osc, b_env,
            b_adr_o, b_data_o, b_gid, b_err};
  endfunction

  typedef struct {
    int         req;
    logic [9:0] a;
    logic [7:0] d;
    logic [4:0] esel;
    logic [6:0] eadr;
    logic       bad;
  } vec_t;

  vec_t tbl[NV];
  int   order[4];
  logic [7:0] rr_dat[3];
  int   nwr;

  // Reference model state for the randomized phase.
  int         m_phase, m_last, m_sec, m_gid, g;
  logic [6:0] m_adr;
  logic [7:0] m_data;
  logic       m_err;
  logic [9:0] s_adr;
  logic [7:0] s_data;
  logic [N-1:0] pend;
  logic [N-1:0] e_rdy;
  logic [4:0]   e_sel;
  logic         e_wr, e_busy;

  initial begin
    tbl[0] = '{0, 10'h085, 8'h40, 5'b00010, 7'h05, 1'b0};
    tbl[1] = '{1, 10'h000, 8'h01, 5'b00001, 7'h00, 1'b0};
    tbl[2] = '{2, 10'h17F, 8'hA5, 5'b00100, 7'h7F, 1'b0};
    tbl[3] = '{0, 10'h1AA, 8'h5C, 5'b01000, 7'h2A, 1'b0};
    tbl[4] = '{1, 10'h201, 8'hFF, 5'b10000, 7'h01, 1'b0};
    tbl[5] = '{2, 10'h3C0, 8'h12, 5'b00000, 7'h40, 1'b1};
    tbl[6] = '{0, 10'h2A5, 8'h34, 5'b00000, 7'h25, 1'b1};
    order  = '{0, 1, 2, 0};
    rr_dat = '{8'h11, 8'h22, 8'h33};

    // Reset values, even with requests pending.
    req_valid = 3'b111;
    b_valid   = 3'b111;
    mid();
    check("reset_outputs", pack0(), 32'h0);
    check("reset_outputs_h3", pack1(), 32'h0);
    next_cycle();
    reset1 = 1'b1; req_valid = '0; b_valid = '0;

    // Three held requesters: grants 0,1,2,0 four cycles apart.
    next_cycle();
    req_adr = {10'h10A, 10'h083, 10'h005};
    req_data = {8'h33, 8'h22, 8'h11};
    req_valid = 3'b111;
    nwr = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) next_cycle();
      mid();
      if (c % 4 == 0) check("rr_ready", 32'(req_ready), 32'(1) << order[c/4]);
      else check("rr_noready", 32'(req_ready), 32'h0);
      if (c % 4 == 1) begin
        check("rr_gid", 32'(grant_id), 32'(order[c/4]));
        check("rr_data", 32'(data), 32'(rr_dat[order[c/4]]));
      end
      nwr += int'(write);
    end
    check("rr_writes", 32'(nwr), 32'd4);
    next_cycle();
    req_valid = '0;

    // Single osc request from 0; requester 1 arrives mid-transaction and waits for IDLE.
    next_cycle();
    req_adr[9:0] = 10'h085; req_data[7:0] = 8'h40;
    req_adr[19:10] = 10'h001; req_data[15:8] = 8'h5A;
    req_valid = 3'b001;
    mid();
    check("single_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = 3'b010;
    for (int k = 1; k <= 3; k++) begin
      mid();
      check("late_wait_ready", 32'(req_ready), 32'h0);
      check("single_sel", 32'(sel), 32'b00010);
      check("single_adr", 32'(adr), 32'h05);
      check("single_data", 32'(data), 32'h40);
      check("single_write", 32'(write), (k == 2) ? 32'h1 : 32'h0);
      next_cycle();
    end
    mid();
    check("single_idle_busy", 32'(busy), 32'h0);
    check("late_ready1", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = '0;
    mid();
    check("late_gid", 32'(grant_id), 32'h1);
    check("late_adr", 32'(adr), 32'h01);
    for (int k = 0; k < 3; k++) next_cycle();

    // Bad section consumed; a good request is accepted in the very next cycle.
    req_adr[29:20] = 10'h3C0;
    req_valid = 3'b100;
    mid();
    check("bad_ready", 32'(req_ready), 32'h4);
    next_cycle();
    req_data[7:0] = 8'h77;
    req_valid = 3'b001;
    mid();
    check("bad_err", 32'(err_badadr), 32'h1);
    check("bad_next_ready", 32'(req_ready), 32'h1);
    check("bad_nowrite", 32'({write, busy, sel}), 32'h0);
    next_cycle();
    req_valid = '0;
    mid();
    check("bad_err_clear", 32'(err_badadr), 32'h0);
    check("bad_next_sel", 32'(sel), 32'b00010);
    check("bad_next_data", 32'(data), 32'h77);
    for (int k = 0; k < 3; k++) next_cycle();

    // Table of single transactions.
    for (int i = 0; i < NV; i++) begin
      next_cycle();
      req_valid = '0;
      req_valid[tbl[i].req] = 1'b1;
      req_adr[tbl[i].req*10 +: 10] = tbl[i].a;
      req_data[tbl[i].req*8 +: 8] = tbl[i].d;
      mid();
      check("tbl_ready", 32'(req_ready), 32'(1) << tbl[i].req);
      next_cycle();
      req_valid = '0;
      mid();
      check("tbl_sel", 32'(sel), 32'(tbl[i].esel));
      check("tbl_adr", 32'(adr), 32'(tbl[i].eadr));
      check("tbl_err", 32'(err_badadr), 32'(tbl[i].bad));
      check("tbl_gid", 32'(grant_id), 32'(tbl[i].req));
      check("tbl_busy", 32'(busy), 32'(!tbl[i].bad));
      if (!tbl[i].bad) begin
        check("tbl_data", 32'(data), 32'(tbl[i].d));
        next_cycle(); mid();
        check("tbl_strobe", 32'({write, sel}), 32'({1'b1, tbl[i].esel}));
        next_cycle(); mid();
        check("tbl_hold", 32'({write, busy, sel}), 32'({2'b01, tbl[i].esel}));
        next_cycle(); mid();
        check("tbl_idle", 32'({write, busy, sel}), 32'h0);
      end else begin
        next_cycle(); mid();
        check("tbl_err_once", 32'({err_badadr, write, busy, sel}), 32'h0);
      end
    end

    // HOLD_CYC = 3: com select and busy for 5 cycles, write in the second.
    next_cycle();
    b_adr[9:0] = 10'h201; b_data[7:0] = 8'hFF; b_valid = 3'b001;
    mid();
    check("h3_ready", 32'(b_ready), 32'h1);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      b_valid = '0;
      mid();
      check("h3_com", 32'(b_com), (k <= 5) ? 32'h1 : 32'h0);
      check("h3_busy", 32'(b_busy), (k <= 5) ? 32'h1 : 32'h0);
      check("h3_write", 32'(b_write), (k == 2) ? 32'h1 : 32'h0);
      if (k == 1) check("h3_adrdata", 32'({b_adr_o, b_data_o}), 32'({7'h01, 8'hFF}));
    end
    check("h3_idle", pack1() & 32'h0FF8_0000, 32'h0);

    // Reset during the strobe: outputs drop at once, round-robin restarts at 0.
    next_cycle();
    req_adr[9:0] = 10'h085; req_data[7:0] = 8'h40; req_valid = 3'b001;
    mid();
    check("rst_ready", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    next_cycle();
    mid();
    check("rst_strobe_before", 32'(write), 32'h1);
    #1 reset1 = 1'b0;
    #1;
    check("rst_async_clear", pack0(), 32'h0);
    next_cycle();
    reset1 = 1'b1;
    req_adr[19:10] = 10'h000;
    req_valid = 3'b011;
    mid();
    check("rst_first_grant", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    mid();
    check("rst_gid", 32'({grant_id, busy}), 32'({2'd0, 1'b1}));
    for (int k = 0; k < 4; k++) next_cycle();

    // Randomized traffic against a transaction-level model.
    reset1 = 1'b0;
    next_cycle();
    reset1 = 1'b1;
    m_phase = 0; m_last = N - 1; m_sec = 0; m_gid = 0; m_adr = '0; m_data = '0; m_err = 1'b0;
    g = -1; pend = '0; s_adr = '0; s_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      if (g >= 0) begin
        m_sec = int'(s_adr[9:7]);
        m_adr = s_adr[6:0];
        m_data = s_data;
        m_gid = g;
        m_last = g;
        m_err = (m_sec > 4);
        m_phase = (m_sec > 4) ? 0 : 1;
        pend[g] = 1'b0;
      end else begin
        m_err = 1'b0;
        if (m_phase != 0) m_phase = (m_phase == 2 + H) ? 0 : m_phase + 1;
      end
      for (int r = 0; r < N; r++) begin
        if (pend[r]) begin
          if ($urandom_range(15, 0) == 0) pend[r] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          pend[r] = 1'b1;
          req_adr[r*10 +: 10] = 10'($urandom_range(1023, 0));
          req_data[r*8 +: 8] = 8'($urandom);
        end
      end
      req_valid = pend;
      mid();
      g = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      e_rdy = '0;
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        s_adr = req_adr[g*10 +: 10];
        s_data = req_data[g*8 +: 8];
      end
      e_wr = (m_phase == 2);
      e_busy = (m_phase != 0);
      e_sel = e_busy ? 5'(1 << m_sec) : 5'b0;
      check("rand", pack0(), {4'b0, e_rdy, e_wr, e_busy, e_sel, m_adr, m_data, 2'(m_gid), m_err});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
